// File: rtl/controle_varredura_servo.sv
// Position sequencer for circuito_pwm: sweeps largura 0->7->0, settles at each position,
// requests one measurement and steps after fim_medida or a timeout.
module controle_varredura_servo #(
    parameter int unsigned CONF_PERIODO          = 1000000,
    parameter int unsigned PERIODOS_ASSENTAMENTO = 25,
    parameter int unsigned TIMEOUT_MEDIDA        = 3000000,
    parameter logic [2:0]  POS_INICIAL           = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    output logic [2:0] largura,
    output logic       direcao,
    output logic       medir,
    output logic       timeout,
    output logic       varredura_completa,
    output logic [2:0] estado_db
);

    typedef enum logic [2:0] {
        StParado  = 3'b000,
        StAssenta = 3'b001,
        StMede    = 3'b010,
        StAguarda = 3'b011,
        StAvanca  = 3'b100
    } estado_e;

    estado_e     estado_q, estado_d;
    logic [2:0]  largura_q, largura_d;
    logic        direcao_q, direcao_d;
    logic        medir_q, medir_d;
    logic        timeout_q, timeout_d;
    logic        completa_q, completa_d;
    logic [31:0] cont_clk_q, cont_clk_d;
    logic [31:0] cont_per_q, cont_per_d;
    logic [31:0] cont_to_q, cont_to_d;

    always_comb begin
        estado_d   = estado_q;
        largura_d  = largura_q;
        direcao_d  = direcao_q;
        medir_d    = 1'b0;
        timeout_d  = 1'b0;
        completa_d = 1'b0;
        cont_clk_d = cont_clk_q;
        cont_per_d = cont_per_q;
        cont_to_d  = cont_to_q;

        case (estado_q)
            StParado: begin
                cont_clk_d = '0;
                cont_per_d = '0;
                cont_to_d  = '0;
                if (ligar) begin
                    estado_d = StAssenta;
                end
            end

            StAssenta: begin
                if (cont_clk_q == CONF_PERIODO - 1) begin
                    cont_clk_d = '0;
                    if (cont_per_q == PERIODOS_ASSENTAMENTO - 1) begin
                        cont_per_d = '0;
                        estado_d   = StMede;
                        medir_d    = 1'b1;
                    end else begin
                        cont_per_d = cont_per_q + 32'd1;
                    end
                end else begin
                    cont_clk_d = cont_clk_q + 32'd1;
                end
            end

            StMede: begin
                cont_to_d = '0;
                estado_d  = StAguarda;
            end

            StAguarda: begin
                cont_to_d = cont_to_q + 32'd1;
                // fim_medida takes priority over an expiring timeout in the same cycle
                if (fim_medida) begin
                    estado_d = StAvanca;
                end else if (cont_to_q == TIMEOUT_MEDIDA - 1) begin
                    timeout_d = 1'b1;
                    estado_d  = StAvanca;
                end
            end

            StAvanca: begin
                if (!direcao_q) begin
                    if (largura_q == 3'd7) begin
                        largura_d  = 3'd6;
                        direcao_d  = 1'b1;
                        completa_d = 1'b1;
                    end else begin
                        largura_d = largura_q + 3'd1;
                    end
                end else begin
                    if (largura_q == 3'd0) begin
                        largura_d  = 3'd1;
                        direcao_d  = 1'b0;
                        completa_d = 1'b1;
                    end else begin
                        largura_d = largura_q - 3'd1;
                    end
                end
                cont_clk_d = '0;
                cont_per_d = '0;
                cont_to_d  = '0;
                estado_d   = ligar ? StAssenta : StParado;
            end

            default: begin
                estado_d = StParado;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= StParado;
            largura_q  <= POS_INICIAL;
            direcao_q  <= 1'b0;
            medir_q    <= 1'b0;
            timeout_q  <= 1'b0;
            completa_q <= 1'b0;
            cont_clk_q <= '0;
            cont_per_q <= '0;
            cont_to_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            largura_q  <= largura_d;
            direcao_q  <= direcao_d;
            medir_q    <= medir_d;
            timeout_q  <= timeout_d;
            completa_q <= completa_d;
            cont_clk_q <= cont_clk_d;
            cont_per_q <= cont_per_d;
            cont_to_q  <= cont_to_d;
        end
    end

    assign largura            = largura_q;
    assign direcao            = direcao_q;
    assign medir              = medir_q;
    assign timeout            = timeout_q;
    assign varredura_completa = completa_q;
    assign estado_db          = estado_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed bench for controle_varredura_servo with a short settle/timeout configuration.
module tb_controle_varredura_servo;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       fim_medida;
    logic [2:0] largura;
    logic       direcao;
    logic       medir;
    logic       timeout;
    logic       varredura_completa;
    logic [2:0] estado_db;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    controle_varredura_servo #(
        .CONF_PERIODO         (10),
        .PERIODOS_ASSENTAMENTO(2),
        .TIMEOUT_MEDIDA       (50),
        .POS_INICIAL          (3'b000)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ligar             (ligar),
        .fim_medida        (fim_medida),
        .largura           (largura),
        .direcao           (direcao),
        .medir             (medir),
        .timeout           (timeout),
        .varredura_completa(varredura_completa),
        .estado_db         (estado_db)
    );

    typedef struct {
        int         fim_delay;  // cycles after the medir cycle; negative = never answer
        logic [2:0] largura;
        logic       direcao;
        logic       completa;
    } step_t;

    step_t tabela[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_medir(output bit got);
        int n;
        got = 1'b0;
        n   = 0;
        while (!got && n < 60) begin
            @(negedge clock);
            n++;
            if (medir === 1'b1) got = 1'b1;
        end
    endtask

    // One full step: wait for medir, answer (or not), then check the new position.
    task automatic run_step(input int d, input logic [2:0] el, input logic ed, input logic evc,
                            input string tag);
        bit got;
        int n;
        wait_medir(got);
        chk({tag, "_medir_seen"}, 32'(got), 32'd1);
        if (!got) return;
        chk({tag, "_estado_mede"}, 32'(estado_db), 32'd2);
        if (d < 0) begin
            got = 1'b0;
            n   = 0;
            while (!got && n < 100) begin
                @(negedge clock);
                n++;
                if (timeout === 1'b1) got = 1'b1;
            end
            chk({tag, "_timeout_delay"}, got ? 32'(n) : 32'd0, 32'd51);
        end else begin
            repeat (d) @(posedge clock);
            #1 fim_medida = 1'b1;
            @(posedge clock);
            #1 fim_medida = 1'b0;
            @(negedge clock);
            chk({tag, "_no_timeout"}, 32'(timeout), 32'd0);
        end
        chk({tag, "_estado_avanca"}, 32'(estado_db), 32'd4);
        @(negedge clock);
        chk({tag, "_largura"}, 32'(largura), 32'(el));
        chk({tag, "_direcao"}, 32'(direcao), 32'(ed));
        chk({tag, "_completa"}, 32'(varredura_completa), 32'(evc));
        chk({tag, "_estado_pos"}, 32'(estado_db), ligar ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        int bad;
        int first;
        int cnt;

        // Sweep from largura=1 back up to 1, then a timeout step ending at 2.
        tabela[0]  = '{3, 3'd2, 1'b0, 1'b0};
        tabela[1]  = '{3, 3'd3, 1'b0, 1'b0};
        tabela[2]  = '{3, 3'd4, 1'b0, 1'b0};
        tabela[3]  = '{3, 3'd5, 1'b0, 1'b0};
        tabela[4]  = '{3, 3'd6, 1'b0, 1'b0};
        tabela[5]  = '{3, 3'd7, 1'b0, 1'b0};
        tabela[6]  = '{3, 3'd6, 1'b1, 1'b1};
        tabela[7]  = '{3, 3'd5, 1'b1, 1'b0};
        tabela[8]  = '{3, 3'd4, 1'b1, 1'b0};
        tabela[9]  = '{3, 3'd3, 1'b1, 1'b0};
        tabela[10] = '{3, 3'd2, 1'b1, 1'b0};
        tabela[11] = '{3, 3'd1, 1'b1, 1'b0};
        tabela[12] = '{3, 3'd0, 1'b1, 1'b0};
        tabela[13] = '{3, 3'd1, 1'b0, 1'b1};
        tabela[14] = '{-1, 3'd2, 1'b0, 1'b0};

        reset      = 1'b0;
        ligar      = 1'b0;
        fim_medida = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_largura", 32'(largura), 32'd0);
        chk("rst_direcao", 32'(direcao), 32'd0);
        chk("rst_medir", 32'(medir), 32'd0);
        chk("rst_estado", 32'(estado_db), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Idle with ligar=0; a stray fim_medida in PARADO must be ignored.
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (c == 50) fim_medida = 1'b1;
            if (c == 51) fim_medida = 1'b0;
            @(negedge clock);
            if (medir !== 1'b0 || estado_db !== 3'd0 || largura !== 3'd0 || direcao !== 1'b0)
                bad++;
        end
        chk("idle_bad_cycles", 32'(bad), 32'd0);

        // Exact latency: ligar at edge k, medir only at k+21, fim at k+25, largura=1 at k+27.
        @(posedge clock);
        #1 ligar = 1'b1;
        @(negedge clock);
        chk("lat_estado_k", 32'(estado_db), 32'd0);
        @(negedge clock);
        chk("lat_estado_k1", 32'(estado_db), 32'd1);
        first = -1;
        cnt   = (medir === 1'b1) ? 1 : 0;
        for (int c = 2; c <= 21; c++) begin
            if (c == 6) fim_medida = 1'b1;
            if (c == 7) fim_medida = 1'b0;
            @(negedge clock);
            if (medir === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
            end
        end
        chk("lat_medir_cycle", 32'(first), 32'd21);
        chk("lat_medir_count", 32'(cnt), 32'd1);
        chk("lat_estado_mede", 32'(estado_db), 32'd2);
        repeat (4) @(posedge clock);
        #1 fim_medida = 1'b1;
        @(posedge clock);
        #1 fim_medida = 1'b0;
        @(negedge clock);
        chk("lat_largura_k26", 32'(largura), 32'd0);
        chk("lat_estado_k26", 32'(estado_db), 32'd4);
        @(negedge clock);
        chk("lat_largura_k27", 32'(largura), 32'd1);
        chk("lat_direcao_k27", 32'(direcao), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_step(tabela[i].fim_delay, tabela[i].largura, tabela[i].direcao,
                     tabela[i].completa, $sformatf("step%0d", i));
        end

        // ligar dropped in ASSENTA at largura=2; fim in the last AGUARDA cycle beats timeout.
        ligar = 1'b0;
        run_step(50, 3'd3, 1'b0, 1'b0, "drop");
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (medir !== 1'b0 || estado_db !== 3'd0 || largura !== 3'd3) bad++;
        end
        chk("drop_parado_bad_cycles", 32'(bad), 32'd0);

        ligar = 1'b1;
        run_step(3, 3'd4, 1'b0, 1'b0, "resume4");
        run_step(3, 3'd5, 1'b0, 1'b0, "resume5");

        // Asynchronous reset in AGUARDA at largura=5.
        wait_medir(got);
        chk("arst_medir_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clock);
        chk("arst_estado_before", 32'(estado_db), 32'd3);
        chk("arst_largura_before", 32'(largura), 32'd5);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_largura", 32'(largura), 32'd0);
        chk("arst_medir", 32'(medir), 32'd0);
        chk("arst_estado", 32'(estado_db), 32'd0);
        chk("arst_direcao", 32'(direcao), 32'd0);
        repeat (2) @(negedge clock);
        chk("arst_hold_estado", 32'(estado_db), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
